// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide RAM port arbiter: access types, FSM states,
// requester identities and the I/O address window.
package mem_arbiter_pkg;

  localparam logic [1:0] LS_WORD        = 2'b00;
  localparam logic [1:0] LS_HALF        = 2'b01;
  localparam logic [1:0] LS_BYTE        = 2'b10;
  localparam int         LS_SIGNED_BIT  = 2;
  localparam logic [2:0] FETCH_TYPE     = {1'b0, LS_WORD};
  localparam logic [1:0] IO_ADDR_HI_DEF = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;
  typedef enum logic {GNT_IF, GNT_LS} grant_t;

  function automatic logic [2:0] access_len(input logic [2:0] t);
    case (t[1:0])
      LS_HALF: return 3'd2;
      LS_BYTE: return 3'd1;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_extend.sv
// Combinational assembly of four little-endian byte lanes into a 32-bit value,
// sign- or zero-extended according to the access type.
module mem_extend
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  ls_type,
  output logic [31:0] ext
);

  logic sgn;

  assign sgn = ls_type[LS_SIGNED_BIT];

  always_comb begin
    case (ls_type[1:0])
      LS_BYTE: ext = {{24{sgn & raw[7]}}, raw[7:0]};
      LS_HALF: ext = {{16{sgn & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and the load/store buffer that
// serialises multi-byte accesses onto a single byte-wide RAM port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic        ls_r_nw,
  input  logic [2:0]  ls_type,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  state_t      state;
  grant_t      cur_gnt, last_gnt, gnt;
  logic        gnt_vld, if_ok;
  logic [31:0] base_addr, wbuf, raw, raw_next, ext, nxt_addr;
  logic [2:0]  typ, len, cnt;
  logic [1:0]  rx_lane, tx_lane;
  logic        wr_q, if_done_q, io_stall;

  // A fetch request coinciding with a flush is stale and must not win a grant.
  assign if_ok = if_req & ~clear_in;

  always_comb begin
    gnt_vld = if_ok | ls_req;
    if (if_ok && ls_req) gnt = (last_gnt == GNT_IF) ? GNT_LS : GNT_IF;
    else                 gnt = ls_req ? GNT_LS : GNT_IF;
  end

  assign io_stall = wr_q & (mem_a[17:16] == IO_ADDR_HI) & io_buffer_full;
  assign mem_wr   = wr_q & ~io_stall;
  assign if_done  = if_done_q & ~clear_in;

  assign rx_lane  = 2'(cnt - 3'd1);
  assign tx_lane  = 2'(cnt + 3'd1);
  assign nxt_addr = base_addr + 32'(cnt) + 32'd1;

  always_comb begin
    raw_next = raw;
    raw_next[{rx_lane, 3'b000} +: 8] = mem_din;
  end

  mem_extend u_extend (
    .raw     (raw_next),
    .ls_type (typ),
    .ext     (ext)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      cur_gnt   <= GNT_IF;
      last_gnt  <= GNT_IF;
      base_addr <= '0;
      wbuf      <= '0;
      raw       <= '0;
      typ       <= '0;
      len       <= '0;
      cnt       <= '0;
      wr_q      <= 1'b0;
      if_done_q <= 1'b0;
      ls_done   <= 1'b0;
      mem_a     <= '0;
      mem_dout  <= '0;
      if_data   <= '0;
      ls_rdata  <= '0;
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            cur_gnt  <= gnt;
            last_gnt <= gnt;
            cnt      <= '0;
            if (gnt == GNT_IF) begin
              base_addr <= if_addr;
              mem_a     <= if_addr;
              typ       <= FETCH_TYPE;
              len       <= 3'd4;
              state     <= ST_READ;
            end else begin
              base_addr <= ls_addr;
              mem_a     <= ls_addr;
              typ       <= ls_type;
              len       <= access_len(ls_type);
              wbuf      <= ls_wdata;
              if (ls_r_nw) begin
                state <= ST_READ;
              end else begin
                state    <= ST_WRITE;
                wr_q     <= 1'b1;
                mem_dout <= ls_wdata[7:0];
              end
            end
          end
        end
        // Address i goes out while byte i-1 returns, so a read of n bytes spans n+1 cycles.
        ST_READ: begin
          if (cur_gnt == GNT_IF && clear_in) begin
            state <= ST_IDLE;
            mem_a <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt != 3'd0) raw <= raw_next;
            if (cnt == len) begin
              state <= ST_DONE;
              mem_a <= '0;
              if (cur_gnt == GNT_IF) begin
                if_data   <= ext;
                if_done_q <= 1'b1;
              end else begin
                ls_rdata <= ext;
                ls_done  <= 1'b1;
              end
            end else if (cnt + 3'd1 < len) begin
              mem_a <= nxt_addr;
            end else begin
              mem_a <= '0;
            end
          end
        end
        ST_WRITE: begin
          if (!io_stall) begin
            if (cnt + 3'd1 == len) begin
              wr_q     <= 1'b0;
              mem_a    <= '0;
              mem_dout <= '0;
              state    <= ST_DONE;
              ls_done  <= 1'b1;
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= nxt_addr;
              mem_dout <= wbuf[{tx_lane, 3'b000} +: 8];
            end
          end
        end
        default: begin
          if_done_q <= 1'b0;
          ls_done   <= 1'b0;
          cnt       <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
